pipelined_adder: RTL and testbench

Parametrised, pipelined add/subtract unit for the adder datapath. It generalises the fixed 8-bit ripple adder to any operand width and splits the carry chain into `STAGES` registered chunks. It adds a subtract mode, a signed-overflow flag and a valid/ready handshake, so it can sit between streaming producers and consumers at higher clock rates.

---
 rtl/adder_pkg.sv | 16 +
 rtl/adder_stage.sv | 57 +++++
 rtl/pipelined_adder.sv | 74 +++++++
 tb/tb_pipelined_adder.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared constants and sizing helpers for the pipelined add/subtract unit.
package adder_pkg;

    localparam int DEFAULT_WIDTH  = 32;
    localparam int DEFAULT_STAGES = 4;

    function automatic int chunk_w(input int width, input int stages);
        return width / stages;
    endfunction

    // valid + sub + carry, then a_rem, b_rem and sum_done, each WIDTH bits
    function automatic int payload_w(input int width);
        return 3 + 3 * width;
    endfunction

endpackage

// File: rtl/adder_stage.sv
// One carry chunk of the pipelined adder: adds its slice and registers the payload.
module adder_stage
    import adder_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int STAGES = DEFAULT_STAGES,
    parameter int IDX    = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en_i,
    input  logic [payload_w(WIDTH)-1:0]  payload_i,
    output logic [payload_w(WIDTH)-1:0]  payload_o
);

    localparam int CHUNK = chunk_w(WIDTH, STAGES);
    localparam int LO    = IDX * CHUNK;

    typedef struct packed {
        logic             valid;
        logic             sub;
        logic             carry;
        logic [WIDTH-1:0] a_rem;
        logic [WIDTH-1:0] b_rem;
        logic [WIDTH-1:0] sum_done;
    } payload_t;

    payload_t         payload_in;
    payload_t         payload_d;
    payload_t         payload_q;
    logic [CHUNK:0]   chunkSum;

    // Bubbles are zeroed here so downstream outputs read zero without extra muxing.
    always_comb begin
        payload_in = payload_t'(payload_i);
        payload_d  = '0;
        chunkSum   = {1'b0, payload_in.a_rem[LO +: CHUNK]}
                   + {1'b0, payload_in.b_rem[LO +: CHUNK]}
                   + (CHUNK + 1)'(payload_in.carry);
        if (payload_in.valid) begin
            payload_d                      = payload_in;
            payload_d.carry                = chunkSum[CHUNK];
            payload_d.sum_done[LO +: CHUNK] = chunkSum[CHUNK-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            payload_q <= '0;
        end else if (en_i) begin
            payload_q <= payload_d;
        end
    end

    assign payload_o = payload_q;

endmodule

// File: rtl/pipelined_adder.sv
// Parametrised pipelined add/subtract unit with valid/ready handshake and overflow flag.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int STAGES = DEFAULT_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    if ((WIDTH < 2) || (STAGES < 1) || ((WIDTH % STAGES) != 0)) begin : gBadParams
        $error("pipelined_adder: WIDTH must be >= 2 and a multiple of STAGES");
    end

    typedef struct packed {
        logic             valid;
        logic             sub;
        logic             carry;
        logic [WIDTH-1:0] a_rem;
        logic [WIDTH-1:0] b_rem;
        logic [WIDTH-1:0] sum_done;
    } payload_t;

    // pipe[k] feeds stage k; pipe[STAGES] is the last stage register, i.e. the output.
    payload_t pipe [STAGES+1];
    logic     adv;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    always_comb begin
        pipe[0]          = '0;
        pipe[0].valid    = in_valid;
        pipe[0].sub      = sub;
        pipe[0].carry    = cin;
        pipe[0].a_rem    = a;
        pipe[0].b_rem    = sub ? ~b : b;
        pipe[0].sum_done = '0;
    end

    for (genvar k = 0; k < STAGES; k++) begin : gStage
        adder_stage #(
            .WIDTH  (WIDTH),
            .STAGES (STAGES),
            .IDX    (k)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .en_i      (adv),
            .payload_i (pipe[k]),
            .payload_o (pipe[k+1])
        );
    end

    // Carry into the MSB is recovered from the MSB sum bit and its operands.
    assign out_valid = pipe[STAGES].valid;
    assign sum       = pipe[STAGES].sum_done;
    assign cout      = pipe[STAGES].carry;
    assign ovf       = pipe[STAGES].a_rem[WIDTH-1] ^ pipe[STAGES].b_rem[WIDTH-1]
                     ^ pipe[STAGES].sum_done[WIDTH-1] ^ pipe[STAGES].carry;

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench: one 8-bit/2-stage DUT for directed steps plus 32-bit DUTs at 1, 4 and 8 stages.
module tb_pipelined_adder;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        int          acc;
        bit          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] dA [4];
    logic [31:0] dB [4];
    logic [31:0] dSum [4];
    logic        dInV [4];
    logic        dInR [4];
    logic        dCin [4];
    logic        dSub [4];
    logic        dOutV [4];
    logic        dOutR [4];
    logic        dCout [4];
    logic        dOvf [4];

    int   widthOf [4]  = '{8, 32, 32, 32};
    int   stagesOf [4] = '{2, 1, 4, 8};
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   latMode = 1'b1;
    exp_t sb [$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : gDut
        localparam int W  = (g == 0) ? 8 : 32;
        localparam int ST = (g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 4 : 8;
        logic [W-1:0] sumW;
        pipelined_adder #(.WIDTH(W), .STAGES(ST)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (dInV[g]),
            .in_ready  (dInR[g]),
            .a         (dA[g][W-1:0]),
            .b         (dB[g][W-1:0]),
            .cin       (dCin[g]),
            .sub       (dSub[g]),
            .out_valid (dOutV[g]),
            .out_ready (dOutR[g]),
            .sum       (sumW),
            .cout      (dCout[g]),
            .ovf       (dOvf[g])
        );
        assign dSum[g] = 32'(sumW);
    end

    task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: plain wide addition; overflow from operand/result sign bits.
    function automatic exp_t model(input int w, input logic [31:0] av, input logic [31:0] bv,
                                   input bit c, input bit s);
        exp_t            m;
        longint unsigned mask, la, lb, full;
        mask   = (64'd1 << w) - 64'd1;
        la     = {32'b0, av} & mask;
        lb     = (s ? ~{32'b0, bv} : {32'b0, bv}) & mask;
        full   = la + lb + longint'(c);
        m.sum  = 32'(full & mask);
        m.cout = full[w];
        m.ovf  = (la[w-1] == lb[w-1]) && (full[w-1] != la[w-1]);
        m.acc  = 0;
        m.lat  = 1'b0;
        return m;
    endfunction

    task automatic applyStimulus(input int j, input bit v, input logic [31:0] av,
                                 input logic [31:0] bv, input bit c, input bit s,
                                 input bit ordy, output bit acc);
        exp_t e, h;
        @(negedge clk);
        dInV[j] = v; dA[j] = av; dB[j] = bv; dCin[j] = c; dSub[j] = s; dOutR[j] = ordy;
        #1;
        chk("in_ready", 34'(dInR[j]), 34'(!dOutV[j] || ordy));
        if (dOutV[j]) begin
            checks++;
            assert (sb.size() > 0) else begin
                errors++;
                $error("[TB] FAIL unexpected_output observed=%h expected=none", dSum[j]);
            end
            if (sb.size() > 0) begin
                h = sb[0];
                chk("sum", 34'(dSum[j]), 34'(h.sum));
                chk("cout", 34'(dCout[j]), 34'(h.cout));
                chk("ovf", 34'(dOvf[j]), 34'(h.ovf));
                if (ordy) begin
                    void'(sb.pop_front());
                    if (h.lat) chk("latency", 34'(cyc - h.acc), 34'(stagesOf[j]));
                end
            end
        end else begin
            chk("bubble_zero", {dCout[j], dOvf[j], dSum[j]}, 34'd0);
        end
        acc = v && dInR[j];
        if (acc) begin
            e     = model(widthOf[j], av, bv, c, s);
            e.acc = cyc;
            e.lat = latMode;
            sb.push_back(e);
        end
        cyc++;
    endtask

    task automatic drain(input int j);
        int t;
        bit a;
        t = 0;
        while (sb.size() > 0 && t < 100) begin
            applyStimulus(j, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, a);
            t++;
        end
        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("[TB] FAIL drain_timeout observed=%0d expected=0", sb.size());
        end
        sb.delete();
    endtask

    task automatic checkOutput(input int j, input string tag);
        chk({tag, "_out_valid"}, 34'(dOutV[j]), 34'd0);
        chk({tag, "_data"}, {dCout[j], dOvf[j], dSum[j]}, 34'd0);
        chk({tag, "_in_ready"}, 34'(dInR[j]), 34'd1);
    endtask

    initial begin
        bit a;
        int k, t, n;
        for (int i = 0; i < 4; i++) begin
            dInV[i] = 1'b0; dA[i] = '0; dB[i] = '0; dCin[i] = 1'b0; dSub[i] = 1'b0; dOutR[i] = 1'b1;
        end

        // Power-on reset
        #1;
        for (int i = 0; i < 4; i++) checkOutput(i, "reset");
        @(negedge clk);
        rst = 1'b0;

        // Adds with carries, wrap and overflow, then subtracts
        applyStimulus(0, 1'b1, 32'd200, 32'd100, 1'b0, 1'b0, 1'b1, a);
        applyStimulus(0, 1'b1, 32'hAB, 32'hCD, 1'b1, 1'b0, 1'b1, a);
        applyStimulus(0, 1'b1, 32'hFF, 32'h01, 1'b0, 1'b0, 1'b1, a);
        applyStimulus(0, 1'b1, 32'h7F, 32'h01, 1'b0, 1'b0, 1'b1, a);
        applyStimulus(0, 1'b1, 32'h05, 32'h03, 1'b1, 1'b1, 1'b1, a);
        applyStimulus(0, 1'b1, 32'h03, 32'h05, 1'b1, 1'b1, 1'b1, a);
        applyStimulus(0, 1'b1, 32'h80, 32'h01, 1'b1, 1'b1, 1'b1, a);
        drain(0);

        // Backpressure: six beats with a three-cycle consumer stall mid-stream
        latMode = 1'b0;
        k = 0;
        t = 0;
        while (k < 6 && t < 50) begin
            applyStimulus(0, 1'b1, 32'(8'h10 + k), 32'(8'h21 * k), 1'b0, 1'b0,
                          !(t >= 3 && t < 6), a);
            if (a) k++;
            t++;
        end
        chk("bp_accepted", 34'(k), 34'd6);
        drain(0);

        // Reset with two beats in flight
        latMode = 1'b1;
        applyStimulus(0, 1'b1, 32'h11, 32'h22, 1'b0, 1'b0, 1'b1, a);
        applyStimulus(0, 1'b1, 32'h33, 32'h44, 1'b0, 1'b0, 1'b1, a);
        @(posedge clk);
        #1;
        chk("pre_reset_out_valid", 34'(dOutV[0]), 34'd1);
        rst     = 1'b1;
        dInV[0] = 1'b0;
        #1;
        checkOutput(0, "midreset");
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) applyStimulus(0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, a);

        // 32-bit sweep: stall-free latency phase, then random handshakes
        for (int j = 1; j < 4; j++) begin
            latMode = 1'b1;
            for (int i = 0; i < 100; i++)
                applyStimulus(j, 1'($urandom), $urandom, $urandom, 1'($urandom), 1'($urandom), 1'b1, a);
            drain(j);
            latMode = 1'b0;
            n = 0;
            t = 0;
            while (n < 1000 && t < 5000) begin
                applyStimulus(j, 1'($urandom), $urandom, $urandom, 1'($urandom), 1'($urandom),
                              1'($urandom), a);
                if (a) n++;
                t++;
            end
            chk("sweep_beats", 34'(n), 34'd1000);
            drain(j);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
